// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_pkg                                                                  |
// | Shared constants, the prefetch entry type and a PC alignment helper for    |
// | the instruction fetch stage.                                               |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_INC           = 32'd4;

    // One prefetch buffer slot: the word and the PC it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Force an address onto a word boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instruction_fetch_if                                                       |
// | Bundles the instruction-memory bus, the redirect input and the decoder     |
// | handshake of the fetch stage. master = fetch unit, slave = its neighbours. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface instruction_fetch_if;
    import fetch_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            instr_valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_ready;
    logic            misaligned;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, misaligned,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, misaligned,
        output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
    );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_fifo                                                                 |
// | Synchronous FIFO of {pc, instr} entries with push/pop/flush and an         |
// | occupancy count. Flush dominates push and pop. DEPTH must be a power of 2. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_push,
    input  wire logic              i_pop,
    input  wire logic              i_flush,
    input  var  fetch_entry_t      i_data,
    output fetch_entry_t           o_data,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push  = i_push && !i_flush;
    assign w_pop   = i_pop && !i_flush && (r_count != '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage, wrapping pointers and occupancy; storage is cleared so the head reads 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instruction_fetch                                                          |
// | Fetch stage: owns the PC, issues word requests to instruction memory,      |
// | buffers returned words in a prefetch FIFO and hands them to the decoder.   |
// | Redirects flush the buffer and discard responses still owed by memory.     |
// | Optional: define FETCH_MISALIGN_TRAP_EN to flag and halt on misaligned     |
// | redirect targets; otherwise the low two target bits are ignored.           |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int              FIFO_DEPTH = 2
) (
    input  wire logic           clk,
    input  wire logic           reset,
    instruction_fetch_if.master bus
);

    localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]   C_DEPTH = (CW+1)'(FIFO_DEPTH);

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_discard;
    logic            r_halt;

    logic [CW-1:0]   w_fifo_count;
    logic [CW-1:0]   w_outstanding_nxt;
    logic [CW:0]     w_used;
    logic            w_req;
    logic            w_issue;
    logic            w_pop;
    logic            w_push;
    logic [XLEN-1:0] w_target;
    logic            w_target_bad;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_entry;

    // A pop this cycle frees a slot, so it counts as credit; this keeps one instruction per cycle.
    assign w_pop   = (w_fifo_count != '0) && bus.instr_ready && !bus.redirect;
    assign w_used  = {1'b0, r_outstanding} + {1'b0, w_fifo_count} - {{CW{1'b0}}, w_pop};
    assign w_req   = !reset && !r_halt && (w_used < C_DEPTH);
    assign w_issue = w_req && bus.imem_gnt;
    assign w_push  = bus.imem_rvalid && (r_discard == '0);

    assign w_push_entry = '{pc: r_resp_pc, instr: bus.imem_rdata};
    assign w_target     = word_align(bus.redirect_pc);

`ifdef FETCH_MISALIGN_TRAP_EN
    assign w_target_bad = (bus.redirect_pc[1:0] != 2'b00);
`else
    logic w_unused_target_lsbs;
    assign w_unused_target_lsbs = ^bus.redirect_pc[1:0];
    assign w_target_bad         = 1'b0;
`endif

    // Responses owed after this cycle's grant and response have been accounted for.
    always_comb begin
        w_outstanding_nxt = r_outstanding;
        if (w_issue && !bus.imem_rvalid) begin
            w_outstanding_nxt = r_outstanding + CW'(1);
        end else if (!w_issue && bus.imem_rvalid) begin
            w_outstanding_nxt = r_outstanding - CW'(1);
        end
    end

    // PC, response tracking and halt state; a redirect marks every owed response for discard.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_halt        <= 1'b0;
        end else if (bus.redirect) begin
            r_fetch_pc    <= w_target;
            r_resp_pc     <= w_target;
            r_outstanding <= w_outstanding_nxt;
            r_discard     <= w_outstanding_nxt;
            r_halt        <= w_target_bad;
        end else begin
            r_outstanding <= w_outstanding_nxt;
            if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + PC_INC;
            end
            if (w_push) begin
                r_resp_pc <= r_resp_pc + PC_INC;
            end
            if (bus.imem_rvalid && (r_discard != '0)) begin
                r_discard <= r_discard - CW'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.redirect),
        .i_data  (w_push_entry),
        .o_data  (w_head),
        .o_count (w_fifo_count)
    );

    assign bus.imem_req    = w_req;
    assign bus.imem_addr   = r_fetch_pc;
    assign bus.instr_valid = (w_fifo_count != '0);
    assign bus.instr       = w_head.instr;
    assign bus.instr_pc    = w_head.pc;
    assign bus.misaligned  = r_halt;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_instruction_fetch                                                       |
// | Directed bench for instruction_fetch with a latency-programmable memory    |
// | responder and an in-order scoreboard of fetched words.                     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_instruction_fetch;
    import fetch_pkg::*;

    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic reset;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_pop = 0;
    int   cyc   = 0;
    int   lat   = 1;

    exp_t        sb[$];
    rsp_t        mem_q[$];
    logic [31:0] m_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    bit          m_halt = 1'b0;
`endif

    always #5 clk = ~clk;

    instruction_fetch_if bus ();

    instruction_fetch #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        @(negedge clk);
        while (!bus.instr_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_instr_valid", 32'(bus.instr_valid), 32'd1);
    endtask

    // Memory responder: in-order responses, each due a programmable number of cycles after its grant.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (reset) begin
            mem_q.delete();
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = INSTR_NOP;
        end else if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_q[0].data;
            void'(mem_q.pop_front());
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = INSTR_NOP;
        end
    end

    // Scoreboard: expected words pushed on grant, popped and compared on decoder accept.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (bus.imem_req) begin
                chk("imem_addr", bus.imem_addr, m_pc);
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            if (m_halt) begin
                chk("req_while_halted", 32'(bus.imem_req), 32'd0);
            end
`endif
            if (bus.imem_req && bus.imem_gnt) begin
                mem_q.push_back('{cyc + lat, word(bus.imem_addr)});
            end
            if (bus.redirect) begin
                sb.delete();
                m_pc = word_align(bus.redirect_pc);
`ifdef FETCH_MISALIGN_TRAP_EN
                m_halt = (bus.redirect_pc[1:0] != 2'b00);
`endif
            end else begin
                if (bus.instr_valid && bus.instr_ready) begin
                    n_pop++;
                    chk("instr_expected", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("instr_pc", bus.instr_pc, e.pc);
                        chk("instr", bus.instr, e.data);
                    end
                end
                if (bus.imem_req && bus.imem_gnt) begin
                    sb.push_back('{m_pc, word(m_pc)});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    initial begin
        int p0;

        // Reset state
        reset           = 1'b1;
        bus.imem_gnt    = 1'b0;
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        m_pc            = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
        chk("rst_imem_addr", bus.imem_addr, 32'h0);
        chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_instr_pc", bus.instr_pc, 32'h0);
        chk("rst_misaligned", 32'(bus.misaligned), 32'd0);

        // Streaming: single-cycle memory, decoder always ready
        @(posedge clk);
        #2;
        reset           = 1'b0;
        bus.imem_gnt    = 1'b1;
        bus.instr_ready = 1'b1;
        @(negedge clk);
        chk("first_req", 32'(bus.imem_req), 32'd1);
        chk("first_addr", bus.imem_addr, 32'h0);
        repeat (4) tick();
        p0 = n_pop;
        repeat (16) tick();
        chk("throughput_16", 32'(n_pop - p0), 32'd16);

        // Decoder stall: credit stops requests, nothing is lost afterwards
        bus.instr_ready = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        chk("stall_req_low", 32'(bus.imem_req), 32'd0);
        chk("stall_in_use", 32'(sb.size()), 32'(DEPTH));
        chk("stall_valid", 32'(bus.instr_valid), 32'd1);
        tick();
        bus.instr_ready = 1'b1;
        repeat (6) tick();

        // Redirect with two responses in flight
        lat          = 3;
        bus.imem_gnt = 1'b0;
        repeat (6) tick();
        chk("drained_before_redirect", 32'(sb.size()), 32'd0);
        bus.imem_gnt = 1'b1;
        tick();
        tick();
        bus.imem_gnt    = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0100;
        @(negedge clk);
        chk("inflight_at_redirect", 32'(mem_q.size()), 32'd2);
        tick();
        bus.redirect = 1'b0;
        bus.imem_gnt = 1'b1;
        @(negedge clk);
        chk("redir1_valid_low", 32'(bus.instr_valid), 32'd0);
        chk("redir1_addr", bus.imem_addr, 32'h0000_0100);
        wait_valid(20);
        chk("redir1_pc", bus.instr_pc, 32'h0000_0100);
        chk("redir1_instr", bus.instr, word(32'h0000_0100));

        // Redirect in the same cycle as a response and a decoder accept
        lat = 1;
        repeat (8) tick();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0100;
        @(negedge clk);
        chk("same_cycle_rvalid", 32'(bus.imem_rvalid), 32'd1);
        chk("same_cycle_valid", 32'(bus.instr_valid), 32'd1);
        tick();
        bus.redirect = 1'b0;
        @(negedge clk);
        chk("redir2_valid_low", 32'(bus.instr_valid), 32'd0);
        chk("redir2_req", 32'(bus.imem_req), 32'd1);
        chk("redir2_addr", bus.imem_addr, 32'h0000_0100);
        repeat (6) tick();

        // Misaligned redirect target
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0102;
        tick();
        bus.redirect = 1'b0;
        @(negedge clk);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_flag_set", 32'(bus.misaligned), 32'd1);
        chk("mis_req_low", 32'(bus.imem_req), 32'd0);
        repeat (4) tick();
        @(negedge clk);
        chk("mis_still_halted", 32'(bus.imem_req), 32'd0);
        tick();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0200;
        tick();
        bus.redirect = 1'b0;
        @(negedge clk);
        chk("mis_flag_clear", 32'(bus.misaligned), 32'd0);
        chk("resume_req", 32'(bus.imem_req), 32'd1);
        chk("resume_addr", bus.imem_addr, 32'h0000_0200);
        wait_valid(20);
        chk("resume_pc", bus.instr_pc, 32'h0000_0200);
`else
        chk("mis_flag_tied", 32'(bus.misaligned), 32'd0);
        chk("mis_req", 32'(bus.imem_req), 32'd1);
        chk("mis_addr_aligned", bus.imem_addr, 32'h0000_0100);
        wait_valid(20);
        chk("mis_pc_aligned", bus.instr_pc, 32'h0000_0100);
`endif
        repeat (6) tick();

        // PC wrap past the top of the address space
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFF8;
        tick();
        bus.redirect = 1'b0;
        @(negedge clk);
        chk("wrap_addr_fff8", bus.imem_addr, 32'hFFFF_FFF8);
        tick();
        tick();
        @(negedge clk);
        chk("wrap_req", 32'(bus.imem_req), 32'd1);
        chk("wrap_addr_0", bus.imem_addr, 32'h0000_0000);
        repeat (6) tick();

        // Reset in the middle of streaming
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_req", 32'(bus.imem_req), 32'd0);
        chk("midrst_valid", 32'(bus.instr_valid), 32'd0);
        chk("midrst_addr", bus.imem_addr, 32'h0);
        sb.delete();
        m_pc = 32'h0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_req", 32'(bus.imem_req), 32'd1);
        chk("post_rst_addr", bus.imem_addr, 32'h0);
        repeat (8) tick();

        // Drain: every granted word must reach the decoder
        bus.imem_gnt = 1'b0;
        repeat (6) tick();
        chk("final_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
